nf_mem_arb: RTL
===============

# nf_mem_arb

Two-port memory arbiter that shares one memory bus between the instruction fetch path and the load/store unit. It sits between the core (`nf_i_lsu` data port and the fetch port) and the single memory/interconnect port. It latches the winning request, holds it on the bus until acknowledge or timeout, and routes acknowledge and read data back to the owner. LSU has priority, with a bounded-burst rule so fetch cannot starve.

## Interface
- `LSU_BURST`, 4: max consecutive LSU grants while fetch is pending (1..15).
- `TIMEOUT`, 255: cycles in a busy state before forced termination; 0 disables (8-bit counter).

- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset. One clock domain.
- `addr_i` in 32: fetch address
- `req_i` in 1: fetch request, level
- `req_ack_i` out 1: fetch acknowledge, 1-cycle pulse
- `rd_i` out 32: fetch read data, valid with `req_ack_i`
- `addr_dm`, `wd_dm` in 32: LSU address / write data
- `we_dm` in 1: LSU write enable
- `size_dm` in 2: LSU size (00 byte, 01 half, 10 word)
- `req_dm` in 1: LSU request, level
- `req_ack_dm` out 1: LSU acknowledge, 1-cycle pulse
- `rd_dm` out 32: LSU read data, valid with `req_ack_dm`
- `addr_mem`, `wd_mem` out 32: bus address / write data
- `we_mem` out 1: bus write enable
- `size_mem` out 2: bus size
- `req_mem` out 1: bus request
- `req_ack_mem` in 1: bus acknowledge
- `rd_mem` in 32: bus read data
- `bus_err` out 1: 1-cycle pulse on timeout

## Operation
- FSM states: `IDLE`, `IFU_BUSY`, `LSU_BUSY`, `GAP`.
- `IDLE` arbitration:
  - If only one requester is active, it wins.
  - If both are active, LSU wins unless `burst_cnt == LSU_BURST`, in which case IFU wins.
- On grant, register the owner's transaction into the `*_mem` registers:
  - IFU grant: `we_mem=0`, `size_mem=2'b10`, `wd_mem=0`.
  - Enter the matching BUSY state.
- `burst_cnt` (4 bit):
  - +1 on an LSU grant while `req_i=1`.
  - Cleared on an IFU grant.
  - Cleared on an LSU grant with `req_i=0`.
  - Saturates at `LSU_BURST`.
- BUSY state:
  - `req_mem=1`.
  - `req_ack_mem` is routed combinationally to the owner's ack.
  - `rd_mem` is routed to the owner's rd.
  - The non-owner's ack is 0 and its rd is 0.
  - Next state on ack is `GAP`.
- `GAP`:
  - Exactly one cycle with `req_mem=0`. This lets the acked requester drop its level request.
  - Then `IDLE`.
- Timeout:
  - `to_cnt` clears on each grant and increments every BUSY cycle.
  - If `TIMEOUT!=0` and `to_cnt==TIMEOUT-1` with no ack, the owner ack pulses with rd=0 and `bus_err` pulses.
  - Next state is `GAP`.
- Ack and timeout in the same cycle: the ack wins, rd = `rd_mem`, and there is no `bus_err`.
- `req_ack_mem` outside BUSY states is ignored.
- Requests that drop while not yet granted are simply not served. No request queue exists.

## Timing
- Reset values:
  - State `IDLE`.
  - All `*_mem` outputs 0.
  - `req_ack_i`, `req_ack_dm`, `rd_i`, `rd_dm` and `bus_err` are 0.
  - `burst_cnt` and `to_cnt` are 0.
- Reset mid-transaction: on the next edge `req_mem` is 0, there is no ack to either side, and state is `IDLE`.
- Sequence with a zero-wait memory:
  - Request seen in `IDLE` at cycle N.
  - `req_mem=1` and `addr_mem` valid in N+1.
  - Ack in N+1 is forwarded in N+1.
  - `GAP` in N+2, `IDLE` in N+3.
- Minimum bus period: 3 cycles per transaction. Latency from request to ack is 1 cycle plus memory wait.
- `*_mem` payload is stable from the grant edge until the edge leaving BUSY.

## Structure
- Shared package `nf_mem_arb_pkg`:
  - State enum `arb_st_t`.
  - Size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Owner enum `{OWN_IFU, OWN_LSU}`.
- One natural sub-module: `nf_mem_arb_cnt`, a parameterised saturating/compare counter used for both `burst_cnt` and `to_cnt`.
- Everything else is flat in `nf_mem_arb`.

## Test plan
- Single LSU write: `addr_dm=0x100`, `wd_dm=0xA5A5A5A5`, `size_dm=10`, `we_dm=1`, memory ack after 2 cycles. Expect:
  - `req_mem` high for 3 cycles with matching payload.
  - `req_ack_dm` pulse concurrent with `req_ack_mem`.
  - `req_ack_i=0` throughout.
- Fetch read: `addr_i=0x200`, `rd_mem=0x00000013`. Expect:
  - `we_mem=0`, `size_mem=10`.
  - `rd_i=0x13` with `req_ack_i`.
  - `rd_dm=0`.
- Contention with `LSU_BURST=4`, both requesting continuously. Expect grant order LSU, LSU, LSU, LSU, IFU, then LSU, with 3-cycle spacing between grants.
- Timeout with `TIMEOUT=8`, LSU request, never ack. Expect:
  - `req_ack_dm` and `bus_err` pulse in the 8th BUSY cycle, with `rd_dm=0`.
  - `GAP`, then `IDLE`.
- Ack coinciding with the timeout cycle: `rd_dm` = `rd_mem` and `bus_err=0`.
- `reset` asserted in the 2nd BUSY cycle. Expect:
  - All outputs 0 on the next edge.
  - A new request after reset is served normally.

Source files
------------

// File: rtl/nf_mem_arb_pkg.sv
// Shared types for the fetch/LSU memory arbiter: FSM states, bus owner,
// access-size codes and the IDLE-state arbitration rule.
package nf_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2,
    GAP      = 2'd3
  } arb_st_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int BURST_W = 4;
  localparam int TO_W    = 8;

  // LSU has priority unless it has already used up its burst allowance
  // while fetch was waiting.
  function automatic owner_t pick_owner(input logic req_ifu,
                                        input logic req_lsu,
                                        input logic burst_full);
    if (req_lsu && !(req_ifu && burst_full))
      return OWN_LSU;
    return OWN_IFU;
  endfunction

endpackage

// File: rtl/nf_mem_arb_cnt.sv
// Saturating up-counter with synchronous clear and a fixed compare tap,
// shared by the LSU burst limiter and the bus timeout.
module nf_mem_arb_cnt #(
  parameter int W   = 4,
  parameter int SAT = 15,
  parameter int CMP = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [W-1:0] SAT_V = W'(SAT);
  localparam logic [W-1:0] CMP_V = W'(CMP);

  logic [W-1:0] cnt_reg;

  // Clear has priority so a grant always restarts the count.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_reg <= '0;
    else if (clr)
      cnt_reg <= '0;
    else if (inc && (cnt_reg != SAT_V))
      cnt_reg <= cnt_reg + W'(1);
  end

  assign hit = (cnt_reg == CMP_V);

endmodule

// File: rtl/nf_mem_arb.sv
// Two-port memory arbiter: shares one bus between instruction fetch and the
// LSU, holds the granted request until ack or timeout, routes ack/data back.
module nf_mem_arb
  import nf_mem_arb_pkg::*;
#(
  parameter int LSU_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  output logic        req_ack_i,
  output logic [31:0] rd_i,
  input  logic [31:0] addr_dm,
  input  logic [31:0] wd_dm,
  input  logic        we_dm,
  input  logic [1:0]  size_dm,
  input  logic        req_dm,
  output logic        req_ack_dm,
  output logic [31:0] rd_dm,
  output logic [31:0] addr_mem,
  output logic [31:0] wd_mem,
  output logic        we_mem,
  output logic [1:0]  size_mem,
  output logic        req_mem,
  input  logic        req_ack_mem,
  input  logic [31:0] rd_mem,
  output logic        bus_err
);

  localparam logic TO_EN  = (TIMEOUT != 0);
  localparam int   TO_CMP = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  arb_st_t state;
  owner_t  win;
  logic    busy;
  logic    grant;
  logic    burst_full;
  logic    burst_inc;
  logic    to_hit;
  logic    tmo;
  logic    done;

  assign busy  = (state == IFU_BUSY) || (state == LSU_BUSY);
  assign grant = (state == IDLE) && (req_i || req_dm);
  assign win   = pick_owner(req_i, req_dm, burst_full);

  // Only back-to-back LSU grants with fetch still waiting count toward the burst.
  assign burst_inc = (win == OWN_LSU) && req_i;

  nf_mem_arb_cnt #(
    .W   (BURST_W),
    .SAT (LSU_BURST),
    .CMP (LSU_BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (grant && !burst_inc),
    .inc   (grant && burst_inc),
    .hit   (burst_full)
  );

  nf_mem_arb_cnt #(
    .W   (TO_W),
    .SAT ((1 << TO_W) - 1),
    .CMP (TO_CMP)
  ) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (grant),
    .inc   (busy),
    .hit   (to_hit)
  );

  // A real ack in the timeout cycle wins over the forced termination.
  assign tmo  = TO_EN && busy && to_hit && !req_ack_mem;
  assign done = busy && (req_ack_mem || tmo);

  assign req_ack_i  = (state == IFU_BUSY) && done;
  assign req_ack_dm = (state == LSU_BUSY) && done;
  assign rd_i       = ((state == IFU_BUSY) && req_ack_mem) ? rd_mem : '0;
  assign rd_dm      = ((state == LSU_BUSY) && req_ack_mem) ? rd_mem : '0;
  assign bus_err    = tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_mem <= '0;
      wd_mem   <= '0;
      we_mem   <= 1'b0;
      size_mem <= SZ_BYTE;
      req_mem  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            req_mem <= 1'b1;
            if (win == OWN_LSU) begin
              addr_mem <= addr_dm;
              wd_mem   <= wd_dm;
              we_mem   <= we_dm;
              size_mem <= size_dm;
              state    <= LSU_BUSY;
            end else begin
              addr_mem <= addr_i;
              wd_mem   <= '0;
              we_mem   <= 1'b0;
              size_mem <= SZ_WORD;
              state    <= IFU_BUSY;
            end
          end
        end
        IFU_BUSY, LSU_BUSY: begin
          if (done) begin
            req_mem <= 1'b0;
            state   <= GAP;
          end
        end
        // One idle bus cycle lets the acked requester drop its level request.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
